// File: rtl/ahb_lite_mem_if.sv
// AHB-Lite bus bundle for the on-chip memory slave.
// The master modport also owns HREADY; in a single-slave system it is looped back from HREADYOUT.
interface ahb_lite_mem_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_lite_mem.sv
// AHB-Lite single-port 32-bit memory slave with optional wait states and endian-selectable byte lanes.
// Optional feature: define AHB_LITE_MEM_RANGE_CHECK_EN to build address/alignment error responses.
//
// state | meaning
// IDLE  | bus ready; ends a pending data phase and may accept a new address phase
// WAIT  | data phase stalled, wait_cnt counts remaining low cycles down to 0
// ERR1  | first error cycle (HREADYOUT=0, HRESP=1)         [range-check build only]
// ERR2  | second error cycle (HREADYOUT=1, HRESP=1)        [range-check build only]
module ahb_lite_mem #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h1FC0_0000
) (
    input  logic          HCLK,
    input  logic          SI_Reset,
    input  logic          SI_Endian,
    ahb_lite_mem_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
`ifdef AHB_LITE_MEM_RANGE_CHECK_EN
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;
`endif

    logic [1:0]        state;
    logic [3:0]        wait_cnt;
    logic              active_q;
    logic              write_q;
    logic [ADDR_W-1:0] idx_q;
    logic [1:0]        off_q;
    logic [2:0]        size_q;

    logic [31:0]       mem [2**ADDR_W];

    logic              ready;
    logic              resp;
    logic              accept;
    logic              phase_end;
    logic [3:0]        lane_en;
    logic              unused_bits;

    assign unused_bits = ^{bus.HADDR[31:ADDR_W+2], bus.HTRANS[0]};

    always_comb begin
        ready = 1'b1;
        resp  = 1'b0;
        case (state)
            ST_WAIT: ready = 1'b0;
`ifdef AHB_LITE_MEM_RANGE_CHECK_EN
            ST_ERR1: begin
                ready = 1'b0;
                resp  = 1'b1;
            end
            ST_ERR2: resp = 1'b1;
`endif
            default: ready = 1'b1;
        endcase
    end

    // Gating with our own ready keeps a stalled phase safe from a misbehaving HREADY.
    assign accept    = bus.HSEL && bus.HREADY && bus.HTRANS[1] && ready;
    assign phase_end = active_q && (state == ST_IDLE);

`ifdef AHB_LITE_MEM_RANGE_CHECK_EN
    logic addr_err;

    always_comb begin
        addr_err = 1'b0;
        if (bus.HADDR[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2])
            addr_err = 1'b1;
        case (bus.HSIZE)
            3'b000:  ;
            3'b001:  if (bus.HADDR[0]) addr_err = 1'b1;
            3'b010:  if (bus.HADDR[1:0] != 2'b00) addr_err = 1'b1;
            default: addr_err = 1'b1;
        endcase
    end
`endif

    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            active_q <= 1'b0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            off_q    <= 2'b00;
            size_q   <= 3'b000;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd1)
                        state <= ST_IDLE;
                    wait_cnt <= wait_cnt - 4'd1;
                end
`ifdef AHB_LITE_MEM_RANGE_CHECK_EN
                ST_ERR1: state <= ST_ERR2;
`endif
                default: begin
                    active_q <= 1'b0;
                    state    <= ST_IDLE;
                    if (accept) begin
                        idx_q   <= bus.HADDR[ADDR_W+1:2];
                        off_q   <= bus.HADDR[1:0];
                        size_q  <= bus.HSIZE;
                        write_q <= bus.HWRITE;
`ifdef AHB_LITE_MEM_RANGE_CHECK_EN
                        if (addr_err)
                            state <= ST_ERR1;
                        else
`endif
                        begin
                            active_q <= 1'b1;
                            if (WAIT_STATES != 0) begin
                                state    <= ST_WAIT;
                                wait_cnt <= WAIT_STATES[3:0];
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Lanes are fixed AHB byte lanes; big-endian mirrors the byte offset within the word.
    always_comb begin
        lane_en = 4'b0000;
        case (size_q)
            3'b000:  lane_en[off_q ^ {2{SI_Endian}}] = 1'b1;
            3'b001:  lane_en = (off_q[1] ^ SI_Endian) ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // No reset on the array: contents survive SI_Reset.
    always_ff @(posedge HCLK) begin
        if (phase_end && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i])
                    mem[idx_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
            end
        end
    end

    assign bus.HRDATA    = (active_q && !write_q) ? mem[idx_q] : 32'h0;
    assign bus.HREADYOUT = ready;
    assign bus.HRESP     = resp;

endmodule
